// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the unified-memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int WORD_SIZE       = 16;
  localparam int ARB_LATENCY_DEF = 2;
  localparam int CNT_W           = 4;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory bus bundled for the arbiter; slave = arbiter side.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic  if_req;
  word_t if_addr;
  word_t if_rdata;
  logic  if_ready;
  logic  d_req;
  logic  d_we;
  word_t d_addr;
  word_t d_wdata;
  word_t d_rdata;
  logic  d_ready;
  logic  readM;
  logic  writeM;
  word_t address;
  word_t mem_wdata;
  word_t mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, readM, writeM, address, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, readM, writeM, address, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_wait.sv
// mem_wait_counter: loads LATENCY-1 on grant, counts down while busy, done at zero.
module mem_wait_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = ARB_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic done
);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (load)           cnt <= LOAD_VAL;
    else if (en && cnt != 0) cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports, one access at a time.
// Define ARB_ROUND_ROBIN_EN for alternating grants on collision; default is data-first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY = ARB_LATENCY_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);
  arb_state_e state, state_n;
  logic       elig_i, elig_d, grant_i, grant_d, done;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;
`endif

  mem_wait_counter #(.LATENCY(LATENCY)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (grant_i | grant_d),
    .en      (state != ARB_IDLE),
    .done    (done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    // A port's req is still high during its own ready cycle; don't re-grant it.
    elig_i  = bus.if_req && !bus.if_ready;
    elig_d  = bus.d_req  && !bus.d_ready;
    grant_i = 1'b0;
    grant_d = 1'b0;
    state_n = state;
    case (state)
      ARB_IDLE: begin
        if (elig_i && elig_d) begin
`ifdef ARB_ROUND_ROBIN_EN
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else if (elig_d) begin
          grant_d = 1'b1;
        end else if (elig_i) begin
          grant_i = 1'b1;
        end
        if (grant_d)      state_n = ARB_BUSY_D;
        else if (grant_i) state_n = ARB_BUSY_I;
      end
      ARB_BUSY_I, ARB_BUSY_D: if (done) state_n = ARB_IDLE;
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readM     <= 1'b0;
      bus.writeM    <= 1'b0;
      bus.address   <= '0;
      bus.mem_wdata <= '0;
      bus.if_ready  <= 1'b0;
      bus.d_ready   <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d        <= 1'b0;
`endif
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      if (grant_d) begin
        bus.address   <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.readM     <= !bus.d_we;
        bus.writeM    <= bus.d_we;
`ifdef ARB_ROUND_ROBIN_EN
        last_d        <= 1'b1;
`endif
      end else if (grant_i) begin
        bus.address <= bus.if_addr;
        bus.readM   <= 1'b1;
        bus.writeM  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      <= 1'b0;
`endif
      end else if (state != ARB_IDLE && done) begin
        bus.readM  <= 1'b0;
        bus.writeM <= 1'b0;
        if (state == ARB_BUSY_I) begin
          bus.if_rdata <= bus.mem_rdata;
          bus.if_ready <= 1'b1;
        end else begin
          // readM still reflects the latched direction of this data access.
          if (bus.readM) bus.d_rdata <= bus.mem_rdata;
          bus.d_ready <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_mem_port_arbiter;
  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if b2();
  mem_port_arbiter_if b1();

  mem_port_arbiter #(.LATENCY(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  mem_port_arbiter #(.LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  // {readM, writeM, if_ready, d_ready}
  wire [3:0] st2 = {b2.readM, b2.writeM, b2.if_ready, b2.d_ready};
  wire [3:0] st1 = {b1.readM, b1.writeM, b1.if_ready, b1.d_ready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {b2.if_req, b2.d_req, b2.d_we} = 3'b000;
    {b2.if_addr, b2.d_addr, b2.d_wdata, b2.mem_rdata} = '0;
    {b1.if_req, b1.d_req, b1.d_we} = 3'b000;
    {b1.if_addr, b1.d_addr, b1.d_wdata, b1.mem_rdata} = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({st2, b2.address, b2.mem_wdata} !== 36'h0) begin
      n_fail++; $display("FAIL reset_bus2: got %h want 0", {st2, b2.address, b2.mem_wdata});
    end
    n_checks++;
    if ({b2.if_rdata, b2.d_rdata} !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata2: got %h want 0", {b2.if_rdata, b2.d_rdata});
    end
    n_checks++;
    if ({st1, b1.address} !== 20'h0) begin
      n_fail++; $display("FAIL reset_bus1: got %h want 0", {st1, b1.address});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    b2.mem_rdata = 16'h6A05; b2.if_addr = 16'h0010; b2.if_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({st2, b2.address} !== {4'b1000, 16'h0010}) begin
        n_fail++; $display("FAIL fetch_strobe c%0d: got %h want %h", c, {st2, b2.address}, {4'b1000, 16'h0010});
      end
    end
    tick();
    n_checks++;
    if ({st2, b2.if_rdata} !== {4'b0010, 16'h6A05}) begin
      n_fail++; $display("FAIL fetch_ready: got %h want %h", {st2, b2.if_rdata}, {4'b0010, 16'h6A05});
    end
    b2.if_req = 1'b0;
    tick();
    n_checks++;
    if (st2 !== 4'b0000) begin
      n_fail++; $display("FAIL fetch_after: got %b want 0000", st2);
    end
  endtask

  task automatic test_write();
    b2.d_we = 1'b1; b2.d_addr = 16'h0100; b2.d_wdata = 16'hBEEF; b2.d_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({st2, b2.address, b2.mem_wdata} !== {4'b0100, 16'h0100, 16'hBEEF}) begin
        n_fail++; $display("FAIL write_strobe c%0d: got %h want %h", c, {st2, b2.address, b2.mem_wdata}, {4'b0100, 16'h0100, 16'hBEEF});
      end
    end
    tick();
    n_checks++;
    if ({st2, b2.d_rdata} !== {4'b0001, 16'h0000}) begin
      n_fail++; $display("FAIL write_ready: got %h want %h", {st2, b2.d_rdata}, {4'b0001, 16'h0000});
    end
    b2.d_req = 1'b0; b2.d_we = 1'b0;
    tick();
    n_checks++;
    if (st2 !== 4'b0000) begin
      n_fail++; $display("FAIL write_after: got %b want 0000", st2);
    end
  endtask

  task automatic test_collision();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    // Fresh reset: data first in both arbitration modes.
    b2.if_addr = 16'h0020; b2.d_addr = 16'h0030; b2.d_we = 1'b0; b2.mem_rdata = 16'h1234;
    b2.if_req = 1'b1; b2.d_req = 1'b1;
    tick(); tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0030}) begin
      n_fail++; $display("FAIL coll1_data_first: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0030});
    end
    tick();
    n_checks++;
    if ({st2, b2.d_rdata} !== {4'b0001, 16'h1234}) begin
      n_fail++; $display("FAIL coll1_d_ready: got %h want %h", {st2, b2.d_rdata}, {4'b0001, 16'h1234});
    end
    b2.d_req = 1'b0; b2.mem_rdata = 16'h4321;
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0020}) begin
      n_fail++; $display("FAIL coll1_fetch_next: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0020});
    end
    tick(); tick();
    n_checks++;
    if ({st2, b2.if_rdata} !== {4'b0010, 16'h4321}) begin
      n_fail++; $display("FAIL coll1_if_ready: got %h want %h", {st2, b2.if_rdata}, {4'b0010, 16'h4321});
    end
    b2.if_req = 1'b0;
    tick();
    // Lone data write so the last grant was data before the next collision.
    b2.d_we = 1'b1; b2.d_addr = 16'h0200; b2.d_wdata = 16'h0F0F; b2.d_req = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (st2 !== 4'b0001) begin
      n_fail++; $display("FAIL lone_write_ready: got %b want 0001", st2);
    end
    b2.d_req = 1'b0; b2.d_we = 1'b0;
    tick();
    b2.if_addr = 16'h0060; b2.d_addr = 16'h0070; b2.mem_rdata = 16'h0BAD;
    b2.if_req = 1'b1; b2.d_req = 1'b1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0060}) begin
      n_fail++; $display("FAIL coll2_first: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0060});
    end
    tick(); tick();
    n_checks++;
    if (st2 !== 4'b0010) begin
      n_fail++; $display("FAIL coll2_first_ready: got %b want 0010", st2);
    end
    b2.if_req = 1'b0;
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0070}) begin
      n_fail++; $display("FAIL coll2_second: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0070});
    end
    tick(); tick();
    n_checks++;
    if (st2 !== 4'b0001) begin
      n_fail++; $display("FAIL coll2_second_ready: got %b want 0001", st2);
    end
    b2.d_req = 1'b0;
`else
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0070}) begin
      n_fail++; $display("FAIL coll2_first: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0070});
    end
    tick(); tick();
    n_checks++;
    if (st2 !== 4'b0001) begin
      n_fail++; $display("FAIL coll2_first_ready: got %b want 0001", st2);
    end
    b2.d_req = 1'b0;
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0060}) begin
      n_fail++; $display("FAIL coll2_second: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0060});
    end
    tick(); tick();
    n_checks++;
    if (st2 !== 4'b0010) begin
      n_fail++; $display("FAIL coll2_second_ready: got %b want 0010", st2);
    end
    b2.if_req = 1'b0;
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    b2.mem_rdata = 16'hA000; b2.if_addr = 16'h0000; b2.if_req = 1'b1;
    tick(); tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0000}) begin
      n_fail++; $display("FAIL b2b_first: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0000});
    end
    tick();
    n_checks++;
    if ({st2, b2.if_rdata} !== {4'b0010, 16'hA000}) begin
      n_fail++; $display("FAIL b2b_first_ready: got %h want %h", {st2, b2.if_rdata}, {4'b0010, 16'hA000});
    end
    b2.if_addr = 16'h0001; b2.mem_rdata = 16'hA001;
    tick();
    n_checks++;
    if (st2 !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_idle_gap: got %b want 0000", st2);
    end
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0001}) begin
      n_fail++; $display("FAIL b2b_second: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0001});
    end
    tick(); tick();
    n_checks++;
    if ({st2, b2.if_rdata} !== {4'b0010, 16'hA001}) begin
      n_fail++; $display("FAIL b2b_second_ready: got %h want %h", {st2, b2.if_rdata}, {4'b0010, 16'hA001});
    end
    b2.if_req = 1'b0;
    tick();
    n_checks++;
    if (st2 !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_after: got %b want 0000", st2);
    end
  endtask

  task automatic test_reset_mid();
    b2.d_we = 1'b0; b2.d_addr = 16'h0040; b2.mem_rdata = 16'h5555; b2.d_req = 1'b1;
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0040}) begin
      n_fail++; $display("FAIL rst_mid_busy: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0040});
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({st2, b2.address, b2.if_rdata, b2.d_rdata} !== 52'h0) begin
      n_fail++; $display("FAIL rst_mid_immediate: got %h want 0", {st2, b2.address, b2.if_rdata, b2.d_rdata});
    end
    b2.d_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (st2 !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_no_ready: got %b want 0000", st2);
    end
    b2.if_addr = 16'h0050; b2.mem_rdata = 16'h7777; b2.if_req = 1'b1;
    tick();
    n_checks++;
    if ({st2, b2.address} !== {4'b1000, 16'h0050}) begin
      n_fail++; $display("FAIL rst_mid_fetch: got %h want %h", {st2, b2.address}, {4'b1000, 16'h0050});
    end
    tick(); tick();
    n_checks++;
    if ({st2, b2.if_rdata, b2.d_rdata} !== {4'b0010, 16'h7777, 16'h0000}) begin
      n_fail++; $display("FAIL rst_mid_fetch_ready: got %h want %h", {st2, b2.if_rdata, b2.d_rdata}, {4'b0010, 16'h7777, 16'h0000});
    end
    b2.if_req = 1'b0;
    tick();
  endtask

  task automatic test_latency1();
    b1.mem_rdata = 16'h1111; b1.if_addr = 16'h0033; b1.if_req = 1'b1;
    tick();
    n_checks++;
    if ({st1, b1.address} !== {4'b1000, 16'h0033}) begin
      n_fail++; $display("FAIL lat1_strobe: got %h want %h", {st1, b1.address}, {4'b1000, 16'h0033});
    end
    tick();
    n_checks++;
    if ({st1, b1.if_rdata} !== {4'b0010, 16'h1111}) begin
      n_fail++; $display("FAIL lat1_ready: got %h want %h", {st1, b1.if_rdata}, {4'b0010, 16'h1111});
    end
    b1.if_req = 1'b0;
    tick();
    n_checks++;
    if (st1 !== 4'b0000) begin
      n_fail++; $display("FAIL lat1_after: got %b want 0000", st1);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
